bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 149 ++++++++++++++
 tb/tb_bit_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer
//  Purpose  : Parallel-to-serial converter with two-word buffering. A word
//             is accepted through a valid/ready handshake and emitted on sout
//             one bit per clock. Consecutive words are emitted with no gap
//             cycle between them. frame_done marks the last bit of each word.
//  Options  : `define BIT_SERIALIZER_LSB_FIRST_EN to emit LSB first
//             (default build emits MSB first).
//  Revision : 1.0  initial release
// ============================================================================
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_active,
    output logic             frame_done
);

    // Bit counter holds the number of bits still to come after the one
    // currently on sout, so zero means "last bit is being presented".
    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sout;
    logic               r_active;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_last;
    logic               w_din_head;
    logic               w_hold_head;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_rotated;

    // The shift register rotates rather than shifts so that every bit of it
    // is consumed; the bit presented next always sits one position behind
    // the head of the word.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    assign w_din_head  = din[0];
    assign w_hold_head = r_hold[0];
    assign w_next_bit  = r_shift[1];
    assign w_rotated   = {r_shift[0], r_shift[WIDTH-1:1]};
`else
    assign w_din_head  = din[WIDTH-1];
    assign w_hold_head = r_hold[WIDTH-1];
    assign w_next_bit  = r_shift[WIDTH-2];
    assign w_rotated   = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
`endif

    // Ready depends only on the holding register, never on din_valid.
    assign din_ready = ~r_hold_full;
    assign w_accept  = din_valid & ~r_hold_full;
    assign w_last    = (r_cnt == '0);

    assign sout        = r_sout;
    assign sout_active = r_active;
    assign frame_done  = r_frame_done;

    // Serializer state machine: loads words, steps bits and manages the hold slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_cnt        <= '0;
            r_sout       <= IDLE_BIT;
            r_active     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // First bit goes straight onto sout at the accept edge.
                        r_shift      <= din;
                        r_sout       <= w_din_head;
                        r_active     <= 1'b1;
                        r_cnt        <= c_CNT_LAST;
                        r_frame_done <= 1'b0;
                        r_state      <= ST_SHIFT;
                    end else begin
                        r_sout       <= IDLE_BIT;
                        r_active     <= 1'b0;
                        r_frame_done <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (!w_last) begin
                        r_shift      <= w_rotated;
                        r_sout       <= w_next_bit;
                        r_cnt        <= r_cnt - c_CNT_ONE;
                        r_frame_done <= (r_cnt == c_CNT_ONE);
                        // A word arriving mid-word waits in the hold slot.
                        if (w_accept) begin
                            r_hold      <= din;
                            r_hold_full <= 1'b1;
                        end
                    end else if (r_hold_full) begin
                        // Held word follows the finished one without a gap.
                        r_shift      <= r_hold;
                        r_sout       <= w_hold_head;
                        r_cnt        <= c_CNT_LAST;
                        r_frame_done <= 1'b0;
                        r_hold_full  <= 1'b0;
                    end else if (w_accept) begin
                        // Word arriving on the final edge bypasses the hold slot.
                        r_shift      <= din;
                        r_sout       <= w_din_head;
                        r_cnt        <= c_CNT_LAST;
                        r_frame_done <= 1'b0;
                    end else begin
                        r_sout       <= IDLE_BIT;
                        r_active     <= 1'b0;
                        r_frame_done <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_sout       <= IDLE_BIT;
                    r_active     <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer
//  Purpose  : Self-checking bench for bit_serializer. A bit-queue model
//             predicts the serial stream; directed sequences pin the model
//             with literal expectations; randomized traffic exercises
//             handshake, backpressure and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

    localparam int   WIDTH    = 8;
    localparam logic IDLE_BIT = 1'b0;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    localparam logic [7:0]  c_STREAM_D8 = 8'b0001_1011;
    localparam logic [15:0] c_DET_MASK  = 16'h0040;
`else
    localparam logic [7:0]  c_STREAM_D8 = 8'b1101_1000;
    localparam logic [15:0] c_DET_MASK  = 16'h0048;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_active;
    logic             frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    bit_serializer #(
        .WIDTH    (WIDTH),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sout        (sout),
        .sout_active (sout_active),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: queue of bits still to appear on sout; head is the bit shown now.
    logic mq_bit[$];
    logic mq_last[$];
    logic m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_bit.delete();
            mq_last.delete();
        end else begin
            // Ready before this edge: no complete word waiting behind the current one.
            m_acc = din_valid && (mq_bit.size() <= WIDTH);
            if (mq_bit.size() > 0) begin
                void'(mq_bit.pop_front());
                void'(mq_last.pop_front());
            end
            if (m_acc) begin
                for (int i = 0; i < WIDTH; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
                    mq_bit.push_back(din[i]);
`else
                    mq_bit.push_back(din[WIDTH-1-i]);
`endif
                    mq_last.push_back(i == WIDTH - 1);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (mq_bit.size() > 0) begin
                chk("cmp_sout",   {31'd0, sout},        {31'd0, mq_bit[0]});
                chk("cmp_active", {31'd0, sout_active}, 32'd1);
                chk("cmp_fdone",  {31'd0, frame_done},  {31'd0, mq_last[0]});
            end else begin
                chk("cmp_sout",   {31'd0, sout},        {31'd0, IDLE_BIT});
                chk("cmp_active", {31'd0, sout_active}, 32'd0);
                chk("cmp_fdone",  {31'd0, frame_done},  32'd0);
            end
            chk("cmp_ready", {31'd0, din_ready}, {31'd0, (mq_bit.size() <= WIDTH)});
        end
    end

    logic [2:0]  hist;
    logic [15:0] det_mask;
    int          n_act;
    int          pct;

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        #1;
        chk("rst_sout",   {31'd0, sout},        {31'd0, IDLE_BIT});
        chk("rst_active", {31'd0, sout_active}, 32'd0);
        chk("rst_fdone",  {31'd0, frame_done},  32'd0);
        chk("rst_ready",  {31'd0, din_ready},   32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Single word 0xD8, accepted at edge 0; observe cycles 1..9.
        din       = 8'hD8;
        din_valid = 1'b1;
        hist      = 3'b000;
        det_mask  = '0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            if (c <= 8) chk("single_sout", {31'd0, sout}, {31'd0, c_STREAM_D8[8-c]});
            else        chk("single_sout_idle", {31'd0, sout}, {31'd0, IDLE_BIT});
            chk("single_active", {31'd0, sout_active}, {31'd0, (c <= 8)});
            chk("single_fdone",  {31'd0, frame_done},  {31'd0, (c == 8)});
            if (sout_active) begin
                hist = {hist[1:0], sout};
                if (hist == 3'b110) det_mask[c] = 1'b1;
            end
        end
        chk("detect_110", {16'd0, det_mask}, {16'd0, c_DET_MASK});
        repeat (3) @(posedge clk);
        #2;

        // Back-to-back 0xD8, 0x6C, then 0xFF under backpressure.
        din       = 8'hD8;
        din_valid = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("b2b_ready_c1", {31'd0, din_ready}, 32'd1);
                din = 8'h6C;
            end
            if (c == 2) din = 8'hFF;
            if (c >= 2 && c <= 8) chk("bp_ready_low", {31'd0, din_ready}, 32'd0);
            if (c == 8 || c == 16 || c == 24) chk("b2b_fdone", {31'd0, frame_done}, 32'd1);
            if (c == 9) begin
                chk("b2b_ready_back", {31'd0, din_ready},   32'd1);
                chk("b2b_no_gap",     {31'd0, sout_active}, 32'd1);
            end
            if (c == 10) din_valid = 1'b0;
            if (c == 17) chk("bp_ff_bit", {31'd0, sout}, 32'd1);
            if (c == 25) chk("b2b_drained", {31'd0, sout_active}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #2;

        // Asynchronous reset during bit 4 of 0xD8 with 0x6C held.
        din       = 8'hD8;
        din_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) din = 8'h6C;
            if (c == 2) din_valid = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sout",   {31'd0, sout},        {31'd0, IDLE_BIT});
        chk("arst_active", {31'd0, sout_active}, 32'd0);
        chk("arst_fdone",  {31'd0, frame_done},  32'd0);
        chk("arst_ready",  {31'd0, din_ready},   32'd1);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        n_act = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (sout_active) n_act++;
        end
        chk("arst_no_resume", n_act, 32'd0);

        // Randomized traffic with varying load and occasional resets.
        pct = 50;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            rst = 1'b0;
            if (n % 250 == 0) begin
                case ((n / 250) % 4)
                    0:       pct = 20;
                    1:       pct = 100;
                    2:       pct = 50;
                    default: pct = 85;
                endcase
            end
            din_valid = ($urandom_range(0, 99) < pct);
            din       = WIDTH'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #1;
                rst = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        rst       = 1'b0;
        din_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
